// File: rtl/b06_pkg.sv
// rtl/b06_pkg.sv - shared codes, limits and state type for the b06 event sense stage
//
// Purpose: CC_MUX channel codes, the debounce state enum and the
//          channel-select helper shared by b06_debounce and b06_event_sense.
// Ports:   none (package).
// Config:  B06_EVENT_SENSE_ACKCHK_EN is handled in the files that use it.

package b06_pkg;

  localparam logic [1:0] CC_NONE  = 2'b00;
  localparam logic [1:0] CC_ENIN  = 2'b01;
  localparam logic [1:0] CC_INTR  = 2'b10;
  localparam logic [1:0] CC_ACKIN = 2'b11;

  // Debounce counter width; wide enough for the largest legal DEB_LEN (15).
  localparam int DEB_CNT_W = 4;

  // The MSB of the encoding is the EQL level, so EQL comes straight off a flop.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RISE = 2'b01,
    HIGH = 2'b10,
    FALL = 2'b11
  } deb_state_t;

  // req bit order: [0] enin, [1] intr, [2] ackin.
  function automatic logic mux_sel(input logic [1:0] cc, input logic [2:0] req);
    logic s;
    s = 1'b0;
    case (cc)
      CC_ENIN:  s = req[0];
      CC_INTR:  s = req[1];
      CC_ACKIN: s = req[2];
      default:  s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/b06_event_sense_if.sv
// rtl/b06_event_sense_if.sv - FSM-facing signal bundle of the b06 event sense stage
//
// Purpose: groups the b06 controller <-> sense stage signals.
// Signals: CC_MUX (FSM->sense) channel select, ENABLE_COUNT (FSM->sense)
//          counter enable, ACKOUT (FSM->sense) acknowledge, EQL (sense->FSM)
//          debounced request, CONT_EQL (sense->FSM) terminal-count pulse,
//          CNT (sense->FSM) current count, ERR (sense->FSM, only with
//          B06_EVENT_SENSE_ACKCHK_EN) sticky enable/ack mismatch.
// Modports: master = controller FSM side, slave = sense stage side.

interface b06_event_sense_if #(
  parameter int CNT_W = 4
);

  logic [2:1]       CC_MUX;
  logic             ENABLE_COUNT;
  logic             ACKOUT;
  logic             EQL;
  logic             CONT_EQL;
  logic [CNT_W-1:0] CNT;
`ifdef B06_EVENT_SENSE_ACKCHK_EN
  logic             ERR;
`endif

  modport master (
    output CC_MUX, ENABLE_COUNT, ACKOUT,
    input  EQL, CONT_EQL, CNT
`ifdef B06_EVENT_SENSE_ACKCHK_EN
    , input ERR
`endif
  );

  modport slave (
    input  CC_MUX, ENABLE_COUNT, ACKOUT,
    output EQL, CONT_EQL, CNT
`ifdef B06_EVENT_SENSE_ACKCHK_EN
    , output ERR
`endif
  );

endinterface

// File: rtl/b06_debounce.sv
// rtl/b06_debounce.sv - request synchroniser, channel select and debounce FSM
//
// Purpose: brings the three asynchronous request lines into the clk domain
//          through 2-flop synchronisers, selects one by cc_mux and filters
//          it so that eql only changes after DEB_LEN+1 stable samples.
// Ports:   clk     in  rising-edge clock
//          rst_n   in  asynchronous reset, active-low
//          cc_mux  in  channel select (00 none, 01 enin, 10 intr, 11 ackin)
//          req     in  [0] enin, [1] intr, [2] ackin, asynchronous
//          eql     out registered debounced level of the selected line

module b06_debounce
  import b06_pkg::*;
#(
  parameter int DEB_LEN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cc_mux,
  input  logic [2:0] req,
  output logic       eql
);

  localparam logic [DEB_CNT_W-1:0] DEB_LEN_C = DEB_CNT_W'(DEB_LEN);
  localparam logic [DEB_CNT_W-1:0] DEB_ONE   = DEB_CNT_W'(1);

  logic [2:0]           sync1;
  logic [2:0]           sync2;
  logic [1:0]           cc_prev;
  deb_state_t           state;
  deb_state_t           state_nxt;
  logic [DEB_CNT_W-1:0] deb_cnt;
  logic [DEB_CNT_W-1:0] deb_cnt_nxt;
  logic                 sel;
  logic                 mux_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      cc_prev <= CC_NONE;
      state   <= IDLE;
      deb_cnt <= '0;
    end else begin
      sync1   <= req;
      sync2   <= sync1;
      cc_prev <= cc_mux;
      state   <= state_nxt;
      deb_cnt <= deb_cnt_nxt;
    end
  end

  assign sel     = mux_sel(cc_mux, sync2);
  assign mux_chg = (cc_mux != cc_prev);

  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    if (mux_chg) begin
      // A new channel restarts any partial debounce from the current settled
      // level; settled levels are kept so EQL cannot glitch on a switch.
      deb_cnt_nxt = '0;
      case (state)
        RISE:    state_nxt = IDLE;
        FALL:    state_nxt = HIGH;
        default: state_nxt = state;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (sel) begin
            state_nxt   = RISE;
            deb_cnt_nxt = DEB_ONE;
          end
        end
        RISE: begin
          if (!sel) begin
            state_nxt = IDLE;
          end else if (deb_cnt == DEB_LEN_C) begin
            state_nxt = HIGH;
          end else begin
            deb_cnt_nxt = deb_cnt + DEB_ONE;
          end
        end
        HIGH: begin
          if (!sel) begin
            state_nxt   = FALL;
            deb_cnt_nxt = DEB_ONE;
          end
        end
        FALL: begin
          if (sel) begin
            state_nxt = HIGH;
          end else if (deb_cnt == DEB_LEN_C) begin
            state_nxt = IDLE;
          end else begin
            deb_cnt_nxt = deb_cnt + DEB_ONE;
          end
        end
        default: begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign eql = (state == HIGH) || (state == FALL);

endmodule

// File: rtl/b06_event_sense.sv
// rtl/b06_event_sense.sv - b06 request sense, debounce and event counter
//
// Purpose: upstream sense stage for the b06 interrupt-handler FSM. Drives
//          EQL from the debounced, CC_MUX-selected request and runs the
//          event counter that returns CONT_EQL at the terminal count.
// Ports:   clk        in  rising-edge clock
//          rst_n      in  asynchronous reset, active-low
//          REQ_ENIN   in  asynchronous enable-in request
//          REQ_INTR   in  asynchronous interrupt request
//          REQ_ACKIN  in  asynchronous acknowledge-in request
//          bus        slave side of b06_event_sense_if (CC_MUX, ENABLE_COUNT,
//                     ACKOUT in; EQL, CONT_EQL, CNT, optional ERR out)
// Config:  B06_EVENT_SENSE_ACKCHK_EN adds the sticky ERR output, set when
//          ENABLE_COUNT != ACKOUT on an edge; ERR freezes the counter.

module b06_event_sense
  import b06_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int LIMIT   = 9,
  parameter int DEB_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic REQ_ENIN,
  input  logic REQ_INTR,
  input  logic REQ_ACKIN,
  b06_event_sense_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             cont_q;
  logic             freeze;

  b06_debounce #(
    .DEB_LEN (DEB_LEN)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .cc_mux (bus.CC_MUX),
    .req    ({REQ_ACKIN, REQ_INTR, REQ_ENIN}),
    .eql    (bus.EQL)
  );

`ifdef B06_EVENT_SENSE_ACKCHK_EN
  logic err_q;

  // Sticky: once the FSM's enable and acknowledge disagree, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bus.ENABLE_COUNT != bus.ACKOUT) begin
      err_q <= 1'b1;
    end
  end

  assign freeze  = err_q;
  assign bus.ERR = err_q;
`else
  logic unused_ackout;

  assign unused_ackout = bus.ACKOUT;
  assign freeze        = 1'b0;
`endif

  // LIMIT bounds the count, so the modulo increment only wraps when
  // LIMIT is the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      cont_q <= 1'b0;
    end else if (!bus.ENABLE_COUNT || freeze) begin
      cont_q <= 1'b0;
    end else if (cnt_q == LIMIT_C) begin
      cnt_q  <= '0;
      cont_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CNT_ONE;
      cont_q <= 1'b0;
    end
  end

  assign bus.CNT      = cnt_q;
  assign bus.CONT_EQL = cont_q;

endmodule

// File: tb/tb_b06_event_sense.sv
// tb/tb_b06_event_sense.sv - self-checking bench for b06_event_sense

module tb_b06_event_sense;
  import b06_pkg::*;

  localparam int CNT_W   = 4;
  localparam int LIMIT   = 9;
  localparam int DEB_LEN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_enin = 1'b0;
  logic req_intr = 1'b0;
  logic req_ackin = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  b06_event_sense_if #(.CNT_W(CNT_W)) bus ();

  b06_event_sense #(
    .CNT_W   (CNT_W),
    .LIMIT   (LIMIT),
    .DEB_LEN (DEB_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .REQ_ENIN  (req_enin),
    .REQ_INTR  (req_intr),
    .REQ_ACKIN (req_ackin),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference model: requests reach the selector after two edges; EQL flips
  // once the selected line has disagreed with it on DEB_LEN+1 consecutive
  // edges with no select change in between.
  logic [2:0] hist1, hist2;
  logic [1:0] m_prev_cc;
  int         m_run;
  logic       m_eql;
  int         m_cnt;
  logic       m_cont;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist1 = '0; hist2 = '0; m_prev_cc = 2'b00; m_run = 0;
    m_eql = 1'b0; m_cnt = 0; m_cont = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic sel;
    logic frozen;
    case (bus.CC_MUX)
      2'b01:   sel = hist2[0];
      2'b10:   sel = hist2[1];
      2'b11:   sel = hist2[2];
      default: sel = 1'b0;
    endcase
    if (bus.CC_MUX != m_prev_cc || sel == m_eql) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEB_LEN + 1) begin
        m_eql = ~m_eql;
        m_run = 0;
      end
    end
    hist2 = hist1;
    hist1 = {req_ackin, req_intr, req_enin};
    m_prev_cc = bus.CC_MUX;
`ifdef B06_EVENT_SENSE_ACKCHK_EN
    frozen = m_err;
    if (bus.ENABLE_COUNT != bus.ACKOUT) m_err = 1'b1;
`else
    frozen = 1'b0;
`endif
    m_cont = 1'b0;
    if (bus.ENABLE_COUNT && !frozen) begin
      if (m_cnt == LIMIT) begin
        m_cnt  = 0;
        m_cont = 1'b1;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end
  endtask

  task automatic check_all();
    check("eql", 32'(bus.EQL), 32'(m_eql));
    check("cnt", 32'(bus.CNT), 32'(m_cnt));
    check("cont_eql", 32'(bus.CONT_EQL), 32'(m_cont));
`ifdef B06_EVENT_SENSE_ACKCHK_EN
    check("err", 32'(bus.ERR), 32'(m_err));
`endif
  endtask

  // Inputs change only at the falling edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called at a falling edge: asynchronous reset must clear CNT before any edge.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(bus.CNT), 32'd0);
    check("async_rst_eql", 32'(bus.EQL), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Steps until EQL reaches val; returns the number of edges taken (bounded).
  task automatic wait_eql(input logic val, input int max, output int lat);
    lat = 0;
    while (bus.EQL !== val && lat < max) begin
      step();
      lat++;
    end
  endtask

  int lat;

  initial begin
    bus.CC_MUX = CC_ENIN;
    bus.ENABLE_COUNT = 1'b0;
    bus.ACKOUT = 1'b0;
    model_reset();

    // Reset then idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_eql", 32'(bus.EQL), 32'd0);
      check("rst_cnt", 32'(bus.CNT), 32'd0);
      check("rst_cont", 32'(bus.CONT_EQL), 32'd0);
    end
    rst_n = 1'b1;
    steps(4);

    // Clean rise and fall on intr.
    bus.CC_MUX = CC_INTR;
    steps(3);
    req_intr = 1'b1;
    wait_eql(1'b1, 20, lat);
    check("rise_latency", 32'(lat), 32'(2 + DEB_LEN + 1));
    steps(4);
    req_intr = 1'b0;
    wait_eql(1'b0, 20, lat);
    check("fall_latency", 32'(lat), 32'(2 + DEB_LEN + 1));

    // Glitch rejection in both directions on enin.
    bus.CC_MUX = CC_ENIN;
    steps(3);
    req_enin = 1'b1; steps(2); req_enin = 1'b0; steps(8);
    check("glitch_high", 32'(bus.EQL), 32'd0);
    req_enin = 1'b1; steps(8);
    req_enin = 1'b0; steps(2); req_enin = 1'b1; steps(8);
    check("glitch_low", 32'(bus.EQL), 32'd1);
    req_enin = 1'b0; steps(8);

    // Select switch from a settled high intr to a low ackin.
    bus.CC_MUX = CC_INTR;
    req_intr = 1'b1;
    steps(10);
    check("sw_pre", 32'(bus.EQL), 32'd1);
    req_ackin = 1'b0;
    bus.CC_MUX = CC_ACKIN;
    step();
    check("sw_hold", 32'(bus.EQL), 32'd1);
    wait_eql(1'b0, 20, lat);
    check("sw_fall", 32'(lat), 32'(DEB_LEN + 1));
    bus.CC_MUX = CC_NONE;
    steps(6);
    check("sw_none", 32'(bus.EQL), 32'd0);
    req_intr = 1'b0;

    // Terminal count.
    bus.ENABLE_COUNT = 1'b1;
    bus.ACKOUT = 1'b1;
    steps(LIMIT + 1);
    check("tc_cnt", 32'(bus.CNT), 32'd0);
    check("tc_pulse", 32'(bus.CONT_EQL), 32'd1);
    steps(2);
    check("tc_after", 32'(bus.CNT), 32'd2);
    check("tc_after_pulse", 32'(bus.CONT_EQL), 32'd0);
    lat = 0;
    while (bus.CNT != 5 && lat < 20) begin
      step();
      lat++;
    end
    bus.ENABLE_COUNT = 1'b0;
    bus.ACKOUT = 1'b0;
    steps(3);
    check("hold_cnt", 32'(bus.CNT), 32'd5);
    check("hold_pulse", 32'(bus.CONT_EQL), 32'd0);

    // Reset mid-count.
    bus.ENABLE_COUNT = 1'b1;
    bus.ACKOUT = 1'b1;
    steps(2);
    async_reset();
    steps(2);

`ifdef B06_EVENT_SENSE_ACKCHK_EN
    // Enable/ack mismatch at CNT=3 freezes the counter at 4.
    async_reset();
    bus.ENABLE_COUNT = 1'b1;
    bus.ACKOUT = 1'b1;
    lat = 0;
    while (bus.CNT != 3 && lat < 20) begin
      step();
      lat++;
    end
    bus.ACKOUT = 1'b0;
    step();
    bus.ACKOUT = 1'b1;
    check("err_set", 32'(bus.ERR), 32'd1);
    check("err_cnt", 32'(bus.CNT), 32'd4);
    steps(5);
    check("err_sticky", 32'(bus.ERR), 32'd1);
    check("err_frozen", 32'(bus.CNT), 32'd4);
    async_reset();
    check("err_clear", 32'(bus.ERR), 32'd0);
`endif

    // Randomised run against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) req_enin = ~req_enin;
      if ($urandom_range(0, 7) == 0) req_intr = ~req_intr;
      if ($urandom_range(0, 7) == 0) req_ackin = ~req_ackin;
      if ($urandom_range(0, 29) == 0) bus.CC_MUX = 2'($urandom_range(0, 3));
      bus.ENABLE_COUNT = ($urandom_range(0, 3) != 0);
`ifdef B06_EVENT_SENSE_ACKCHK_EN
      bus.ACKOUT = ($urandom_range(0, 399) == 0) ? ~bus.ENABLE_COUNT : bus.ENABLE_COUNT;
`else
      bus.ACKOUT = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 499) == 0) async_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
